// File: rtl/gelato_types.sv
// -----------------------------------------------------------------------------
// gelato_types
//   Shared types and constants for the SIMT divergence (split table) logic.
//   - split_entry_t : one reconvergence-stack entry {mask, pc, rpc}
//   - split_state_e : sequencing FSM states of gelato_split_ctrl
//   - stack_op_e    : write-port operation of gelato_split_stack
//   - SPLIT_ROOT    : entry 0 of every warp after reset (all lanes, pc 0,
//                     rpc all-ones so no join can ever pop it)
// -----------------------------------------------------------------------------
package gelato_types;

    localparam int NUM_WARPS   = 8;
    localparam int SPLIT_DEPTH = 4;
    localparam int THREAD_NUM  = 32;
    localparam int ADDR_W      = 32;

    typedef logic [$clog2(NUM_WARPS)-1:0]     warp_num_t;
    typedef logic [$clog2(SPLIT_DEPTH)-1:0]   split_table_num_t;
    // Stack pointer spans 1..SPLIT_DEPTH, so it needs one more bit than an index.
    typedef logic [$clog2(SPLIT_DEPTH+1)-1:0] split_sp_t;
    typedef logic [THREAD_NUM-1:0]            thread_mask_t;
    typedef logic [ADDR_W-1:0]                addr_t;

    typedef struct packed {
        thread_mask_t mask;
        addr_t        pc;
        addr_t        rpc;
    } split_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_JOIN,
        ST_UNIFORM,
        ST_REWRITE,
        ST_PUSH_NT,
        ST_PUSH_T
    } split_state_e;

    typedef enum logic [1:0] {
        STK_NONE,
        STK_PUSH,
        STK_POP,
        STK_REWRITE
    } stack_op_e;

    localparam split_entry_t SPLIT_ROOT = '{mask: '1, pc: '0, rpc: '1};

endpackage

// File: rtl/gelato_idecode_split_if.sv
// -----------------------------------------------------------------------------
// gelato_idecode_split_if
//   Link between I-Decode (master) and the split controller (slave).
//   - warp_num, split_table_num : combinational mask lookup address
//   - thread_mask               : lookup result (0 above the stack pointer)
//   - valid, activate, stall    : a join report is live when
//                                 valid && activate && !stall
//   - updated_pc                : PC that warp_num has just reached
// -----------------------------------------------------------------------------
interface gelato_idecode_split_if;
    import gelato_types::*;

    warp_num_t        warp_num;
    split_table_num_t split_table_num;
    thread_mask_t     thread_mask;
    logic             valid;
    logic             activate;
    logic             stall;
    addr_t            updated_pc;

    modport master (
        output warp_num, split_table_num, valid, activate, stall, updated_pc,
        input  thread_mask
    );

    modport slave (
        input  warp_num, split_table_num, valid, activate, stall, updated_pc,
        output thread_mask
    );

endinterface

// File: rtl/gelato_split_stack.sv
// -----------------------------------------------------------------------------
// gelato_split_stack
//   Per-warp reconvergence stack storage: SPLIT_DEPTH entries plus a stack
//   pointer per warp. One write port, two combinational read ports.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     op, op_warp         write operation (push / pop / rewrite_top) and warp
//     wr_entry            pushed entry; only .pc is used by rewrite_top
//     lk_warp, lk_idx     lookup address  -> lk_mask
//     ctl_warp            control read    -> ctl_sp, top mask/rpc, pc below top
// -----------------------------------------------------------------------------
module gelato_split_stack
    import gelato_types::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  stack_op_e        op,
    input  warp_num_t        op_warp,
    input  split_entry_t     wr_entry,
    input  warp_num_t        lk_warp,
    input  split_table_num_t lk_idx,
    output thread_mask_t     lk_mask,
    input  warp_num_t        ctl_warp,
    output split_sp_t        ctl_sp,
    output thread_mask_t     ctl_top_mask,
    output addr_t            ctl_top_rpc,
    output addr_t            ctl_below_pc
);

    split_entry_t entry [NUM_WARPS][SPLIT_DEPTH];
    split_sp_t    sp    [NUM_WARPS];

    split_table_num_t wr_top_idx;
    split_table_num_t wr_push_idx;
    split_table_num_t ctl_top_idx;
    split_table_num_t ctl_below_idx;

    // The indices wrap modulo SPLIT_DEPTH; the controller never pushes onto a
    // full stack nor reads below the root, so the wrapped values go unused.
    assign wr_top_idx    = split_table_num_t'(sp[op_warp] - split_sp_t'(1));
    assign wr_push_idx   = split_table_num_t'(sp[op_warp]);
    assign ctl_top_idx   = split_table_num_t'(sp[ctl_warp] - split_sp_t'(1));
    assign ctl_below_idx = split_table_num_t'(sp[ctl_warp] - split_sp_t'(2));

    // Popped entries keep their contents; the sp bound hides them from lookups.
    assign lk_mask      = (split_sp_t'(lk_idx) < sp[lk_warp]) ? entry[lk_warp][lk_idx].mask : '0;
    assign ctl_sp       = sp[ctl_warp];
    assign ctl_top_mask = entry[ctl_warp][ctl_top_idx].mask;
    assign ctl_top_rpc  = entry[ctl_warp][ctl_top_idx].rpc;
    assign ctl_below_pc = entry[ctl_warp][ctl_below_idx].pc;

    // NOTE: state registers use <= so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the table is small and lookups must return a defined
            // root mask straight out of reset, so the whole array is reset.
            for (int w = 0; w < NUM_WARPS; w++) begin
                sp[w] <= split_sp_t'(1);
                for (int d = 0; d < SPLIT_DEPTH; d++) begin
                    entry[w][d] <= (d == 0) ? SPLIT_ROOT : '0;
                end
            end
        end else begin
            case (op)
                STK_PUSH: begin
                    entry[op_warp][wr_push_idx] <= wr_entry;
                    sp[op_warp]                 <= sp[op_warp] + split_sp_t'(1);
                end
                STK_POP: begin
                    sp[op_warp] <= sp[op_warp] - split_sp_t'(1);
                end
                STK_REWRITE: begin
                    entry[op_warp][wr_top_idx].pc <= wr_entry.pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gelato_split_ctrl.sv
// -----------------------------------------------------------------------------
// gelato_split_ctrl
//   Per-warp SIMT divergence controller. Owns the split table, arbitrates
//   between decode join reports and execute branch resolutions (joins first),
//   sequences multi-cycle stack updates and issues PC redirects to fetch.
//   Ports:
//     clk, rst_n               clock, synchronous active-low reset
//     idecode                  mask lookup + join reports (slave modport)
//     br_valid/br_ready        branch-resolution handshake
//     br_warp, br_taken_mask   branching warp and lanes taking the branch
//     br_taken_pc, br_nt_pc,
//     br_reconv_pc             target, fall-through, reconvergence PC
//     redirect_valid/_warp/_pc one-cycle redirect to the fetch scheduler
//     err_overflow             pulse: divergent push would overflow, or a
//                              join was dropped with the buffer full
//   Build option GELATO_SPLIT_PERF_EN adds perf_div_cnt / perf_join_cnt.
// -----------------------------------------------------------------------------
module gelato_split_ctrl
    import gelato_types::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    gelato_idecode_split_if.slave idecode,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  warp_num_t             br_warp,
    input  thread_mask_t          br_taken_mask,
    input  addr_t                 br_taken_pc,
    input  addr_t                 br_nt_pc,
    input  addr_t                 br_reconv_pc,
    output logic                  redirect_valid,
    output warp_num_t             redirect_warp,
    output addr_t                 redirect_pc,
    output logic                  err_overflow
`ifdef GELATO_SPLIT_PERF_EN
    ,
    output logic [31:0]           perf_div_cnt,
    output logic [31:0]           perf_join_cnt
`endif
);

    split_state_e state;

    // Single-entry buffer for joins that arrive while a sequence is running.
    logic      pend_valid;
    warp_num_t pend_warp;
    addr_t     pend_pc;

    // Operands of the operation in flight, captured when it is started.
    warp_num_t    op_warp;
    thread_mask_t op_tk;
    thread_mask_t op_nt;
    addr_t        op_pc_t;
    addr_t        op_pc_nt;
    addr_t        op_rpc;

    logic         join_now;
    logic         join_cand;
    logic         join_match;
    logic         br_fire;
    logic         br_uniform;
    logic         br_fits;
    warp_num_t    cand_warp;
    addr_t        cand_pc;
    warp_num_t    ctl_warp;
    thread_mask_t act;
    thread_mask_t tk;

    split_sp_t    ctl_sp;
    thread_mask_t ctl_top_mask;
    addr_t        ctl_top_rpc;
    addr_t        ctl_below_pc;
    stack_op_e    stk_op;
    split_entry_t stk_wdata;

    assign join_now  = idecode.valid && idecode.activate && !idecode.stall;
    assign join_cand = pend_valid || join_now;
    assign cand_warp = pend_valid ? pend_warp : idecode.warp_num;
    assign cand_pc   = pend_valid ? pend_pc   : idecode.updated_pc;

    // One control read port serves everything: in IDLE it looks at the join
    // candidate if there is one (a branch cannot be accepted then), otherwise
    // at the branching warp; during a sequence it follows the captured warp.
    assign ctl_warp   = (state == ST_IDLE) ? (join_cand ? cand_warp : br_warp) : op_warp;
    assign join_match = (ctl_top_rpc == cand_pc) && (ctl_sp > split_sp_t'(1));

    assign br_ready   = rst_n && (state == ST_IDLE) && !pend_valid && !join_now;
    assign br_fire    = br_valid && br_ready;
    assign act        = ctl_top_mask;
    assign tk         = br_taken_mask & act;
    assign br_uniform = (tk == act) || (tk == '0);
    assign br_fits    = ctl_sp <= split_sp_t'(SPLIT_DEPTH - 2);

    gelato_split_stack u_stack (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (stk_op),
        .op_warp      (op_warp),
        .wr_entry     (stk_wdata),
        .lk_warp      (idecode.warp_num),
        .lk_idx       (idecode.split_table_num),
        .lk_mask      (idecode.thread_mask),
        .ctl_warp     (ctl_warp),
        .ctl_sp       (ctl_sp),
        .ctl_top_mask (ctl_top_mask),
        .ctl_top_rpc  (ctl_top_rpc),
        .ctl_below_pc (ctl_below_pc)
    );

    // Stack writes are decoded from the registered state only.
    always_comb begin
        // NOTE: defaults first so no path leaves these unassigned (no latch).
        stk_op    = STK_NONE;
        stk_wdata = '0;
        case (state)
            ST_JOIN:    stk_op = STK_POP;
            ST_REWRITE: begin
                stk_op       = STK_REWRITE;
                stk_wdata.pc = op_rpc;
            end
            ST_PUSH_NT: begin
                stk_op    = STK_PUSH;
                stk_wdata = '{mask: op_nt, pc: op_pc_nt, rpc: op_rpc};
            end
            ST_PUSH_T: begin
                stk_op    = STK_PUSH;
                stk_wdata = '{mask: op_tk, pc: op_pc_t, rpc: op_rpc};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            pend_valid     <= 1'b0;
            pend_warp      <= '0;
            pend_pc        <= '0;
            op_warp        <= '0;
            op_tk          <= '0;
            op_nt          <= '0;
            op_pc_t        <= '0;
            op_pc_nt       <= '0;
            op_rpc         <= '0;
            redirect_valid <= 1'b0;
            redirect_warp  <= '0;
            redirect_pc    <= '0;
            err_overflow   <= 1'b0;
`ifdef GELATO_SPLIT_PERF_EN
            perf_div_cnt   <= '0;
            perf_join_cnt  <= '0;
`endif
        end else begin
            redirect_valid <= 1'b0;
            err_overflow   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        // Buffered join goes first; the buffer is refilled by
                        // a join arriving in this same cycle, if any.
                        pend_valid <= join_now;
                        pend_warp  <= idecode.warp_num;
                        pend_pc    <= idecode.updated_pc;
                        if (join_match) begin
                            op_warp <= pend_warp;
                            state   <= ST_JOIN;
                        end
                    end else if (join_now) begin
                        if (join_match) begin
                            op_warp <= idecode.warp_num;
                            state   <= ST_JOIN;
                        end
                    end else if (br_fire) begin
                        op_warp  <= br_warp;
                        op_tk    <= tk;
                        op_nt    <= act & ~tk;
                        op_pc_nt <= br_nt_pc;
                        op_rpc   <= br_reconv_pc;
                        if (br_uniform) begin
                            op_pc_t <= (tk == act) ? br_taken_pc : br_nt_pc;
                            state   <= ST_UNIFORM;
                        end else if (br_fits) begin
                            op_pc_t <= br_taken_pc;
                            state   <= ST_REWRITE;
                        end else begin
                            err_overflow <= 1'b1;
                        end
                    end
                end
                ST_JOIN: begin
                    // Popping now; the entry below the old top becomes the top.
                    redirect_valid <= 1'b1;
                    redirect_warp  <= op_warp;
                    redirect_pc    <= ctl_below_pc;
                    state          <= ST_IDLE;
`ifdef GELATO_SPLIT_PERF_EN
                    perf_join_cnt  <= perf_join_cnt + 32'd1;
`endif
                end
                ST_UNIFORM: begin
                    redirect_valid <= 1'b1;
                    redirect_warp  <= op_warp;
                    redirect_pc    <= op_pc_t;
                    state          <= ST_IDLE;
                end
                ST_REWRITE: state <= ST_PUSH_NT;
                ST_PUSH_NT: state <= ST_PUSH_T;
                ST_PUSH_T: begin
                    redirect_valid <= 1'b1;
                    redirect_warp  <= op_warp;
                    redirect_pc    <= op_pc_t;
                    state          <= ST_IDLE;
`ifdef GELATO_SPLIT_PERF_EN
                    perf_div_cnt   <= perf_div_cnt + 32'd1;
`endif
                end
                default: state <= ST_IDLE;
            endcase

            // Joins reported mid-sequence are buffered; a second one is lost.
            if ((state != ST_IDLE) && join_now) begin
                if (pend_valid) begin
                    err_overflow <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_warp  <= idecode.warp_num;
                    pend_pc    <= idecode.updated_pc;
                end
            end
        end
    end

endmodule

// File: doc/gelato_split_ctrl.md
# gelato_split_ctrl

Per-warp SIMT divergence controller that owns the split table (reconvergence stack) and sequences every update to it. It sits between I-Decode, which looks up thread masks and reports reconvergence points, and the branch-resolution path in execute, which reports divergent branches. It arbitrates between the two requesters, serializes multi-cycle stack updates, and issues PC redirects to the fetch scheduler.

## Interface
- `NUM_WARPS`, 8, number of warps; `warp_num_t` is `$clog2(NUM_WARPS)` bits.
- `DEPTH`, 4, split entries per warp; `split_table_num_t` is `$clog2(DEPTH)` bits.
- `THREAD_NUM`, 32, threads per warp; width of `thread_mask_t`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `idecode`  modport  `gelato_idecode_split_if.slave`  decode lookup and join reports.
- `br_valid`  in  1  branch-resolution request.
- `br_ready`  out  1  request accepted when `br_valid && br_ready`.
- `br_warp`  in  `warp_num_t`  branching warp.
- `br_taken_mask`  in  `THREAD_NUM`  lanes taking the branch.
- `br_taken_pc`, `br_nt_pc`, `br_reconv_pc`  in  `addr_t` each  branch target, fall-through PC, immediate post-dominator.
- `redirect_valid`  out  1  one-cycle pulse.
- `redirect_warp`  out  `warp_num_t`  warp being redirected.
- `redirect_pc`  out  `addr_t`  new PC.
- `err_overflow`  out  1  one-cycle pulse when a push would exceed `DEPTH`, or when a join is dropped.

## Operation
- Storage: per warp, `DEPTH` entries `{mask, pc, rpc}` plus stack pointer `sp` (1..`DEPTH`). The top entry is `sp-1`.
- Lookup is combinational: `thread_mask = entry[warp_num][split_table_num].mask`. An index at or above `sp` returns 0.
- Join: in a cycle with `valid && activate && !stall`, decode reports that `warp_num` reached `updated_pc`.
  - If `updated_pc == top.rpc` and `sp > 1`, pop the top entry and redirect to the new `top.pc`.
  - Otherwise the report is ignored.
- Branch: on acceptance, `act = top.mask` and `tk = br_taken_mask & act`.
  - Uniform (`tk == act` or `tk == 0`): no stack change; redirect to `br_taken_pc` or `br_nt_pc` respectively.
  - Divergent: rewrite `top.pc := br_reconv_pc`, then push `{act & ~tk, br_nt_pc, br_reconv_pc}`, then push `{tk, br_taken_pc, br_reconv_pc}`, then redirect to `br_taken_pc`.
  - Divergent with `sp + 2 > DEPTH`: pulse `err_overflow`, leave the stack unchanged, issue no redirect.
- FSM states:
  - IDLE → JOIN on a pending or arriving join with matching `rpc`.
  - IDLE → UNIFORM on an accepted uniform branch.
  - IDLE → REWRITE on an accepted divergent branch.
  - REWRITE → PUSH_NT → PUSH_T → IDLE.
  - JOIN and UNIFORM each return to IDLE after one cycle.
- Arbitration: joins have priority. `br_ready = (state == IDLE) && !join_pending && !join_now`.
- Pending join: joins arriving while state != IDLE are latched into a single-entry buffer `{warp, pc}` and serviced first on return to IDLE. A second join arriving while the buffer is full is dropped with an `err_overflow` pulse.

## Timing
- Reset:
  - Every warp gets `sp = 1`, `entry0 = {all-ones, 0, all-ones}`.
  - State IDLE, pending buffer empty.
  - `br_ready = 0` during reset, 1 in the first cycle after.
  - `redirect_valid = 0`, `redirect_warp = 0`, `redirect_pc = 0`, `err_overflow = 0`.
- Redirect latency from the accepting/reporting edge:
  - Uniform branch: 1 cycle.
  - Join: 1 cycle.
  - Divergent branch: 3 cycles.
- Lookups read the registered table. An update on edge N is visible to lookups in cycle N+1; no bypass.
- Join and branch for different warps in the same cycle: the join is serviced and `br_ready = 0`. The branch request must hold `br_valid` and its operands until accepted.
- Reset asserted mid-FSM: abort at the next edge, discard the pending join, suppress any redirect.

## Configuration
- `GELATO_SPLIT_PERF_EN`
  - Defined: adds outputs `perf_div_cnt` and `perf_join_cnt` (32 bits each, wrapping, reset to 0). They count completed divergent pushes and successful pops.
  - Undefined: these ports and their counters do not exist.

## Structure
- Package `gelato_types`: `split_entry_t` `{thread_mask_t mask; addr_t pc; addr_t rpc}`, `split_table_num_t`, FSM enum `split_state_e`, constant `SPLIT_DEPTH`.
- Sub-module `gelato_split_stack`: per-warp entry array and `sp` registers. Single write port with `push`/`pop`/`rewrite_top` ops, combinational read port.

## Test plan
- Reset, then look up warp 3 index 0 → mask `0xFFFFFFFF`; index 1 → 0.
- Warp 0 branch with `tk = 0x0000FFFF`, `taken_pc = 0x100`, `nt_pc = 0x80`, `rpc = 0x200` → redirect `0x100` three cycles after acceptance, `sp = 3`, entry1 mask `0xFFFF0000`.
- Then join warp 0 at `0x200` → redirect `0x80`. A second join at `0x200` → redirect `0x200`, `sp = 1`.
- Warp 2 branch with `tk = 0xFFFFFFFF` → no push, redirect `taken_pc` one cycle later. Same with `tk = 0` → redirect `nt_pc`.
- Nest two divergent branches on warp 1 with `DEPTH = 4` → the second pulses `err_overflow`, `sp` stays 3, no redirect.
- Join for warp 5 arrives during REWRITE of warp 1 → join serviced immediately after PUSH_T, `br_ready` held low meanwhile. A third overlapping join → `err_overflow` pulse.
